mem_arbiter: RTL

Single-port memory arbiter between the core's instruction-fetch requester and data-memory requester, sequencing one external bus transaction at a time. Sits between the pipeline (fetch address/instruction path, MEM-stage address/data path) and the shared memory bus. Generates per-requester stall signals so the hazard logic can freeze the pipeline while a transfer is outstanding.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port bus arbiter between instruction fetch and data memory,
//            one transaction at a time, with per-requester stalls and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    output logic                    o_if_valid,
    output logic                    o_stall_IF,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_dm_valid,
    output logic                    o_stall_MEM,
    output logic                    o_bus_req,
    output logic                    o_bus_we,
    output logic [ADDR_WIDTH-1:0]   o_bus_addr,
    output logic [DATA_WIDTH-1:0]   o_bus_wdata,
    output logic [DATA_WIDTH/8-1:0] o_bus_be,
    input  logic                    i_bus_ack,
    input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
    output logic                    o_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    // The counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_gnt_dm;
    logic                  r_last_dm;
    logic                  r_we;
    logic                  r_to;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_grant_dm;
    logic                  w_timeout;

    // On a tie the requester that did not win last time is granted.
    assign w_grant_dm = i_dm_req & (~i_if_req | ~r_last_dm);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_if_req || i_dm_req) w_next = S_BUSY;
            S_BUSY:  if (i_bus_ack || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt_dm   <= 1'b0;
            r_last_dm  <= 1'b0;
            r_we       <= 1'b0;
            r_to       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_if_req || i_dm_req) begin
                        r_gnt_dm <= w_grant_dm;
                        r_addr   <= w_grant_dm ? i_dm_addr : i_if_addr;
                        r_we     <= w_grant_dm & i_dm_we;
                        r_wdata  <= w_grant_dm ? i_dm_wdata : '0;
                        r_be     <= w_grant_dm ? i_dm_be : '1;
                        r_cnt    <= '0;
                        r_to     <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (i_bus_ack) begin
                        if (!r_gnt_dm)  r_if_rdata <= i_bus_rdata;
                        else if (!r_we) r_dm_rdata <= i_bus_rdata;
                    end else if (w_timeout) begin
                        // Aborted reads return zero; a write leaves read data alone.
                        r_to <= 1'b1;
                        if (!r_gnt_dm)  r_if_rdata <= '0;
                        else if (!r_we) r_dm_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: r_last_dm <= r_gnt_dm;
                default: ;
            endcase
        end
    end

    assign o_bus_req   = (r_state == S_BUSY);
    assign o_bus_we    = (r_state == S_BUSY) & r_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_be    = r_be;

    assign o_if_valid  = (r_state == S_RESP) & ~r_gnt_dm;
    assign o_dm_valid  = (r_state == S_RESP) &  r_gnt_dm;
    assign o_err       = (r_state == S_RESP) &  r_to;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;

    assign o_stall_IF  = i_if_req & ~o_if_valid;
    assign o_stall_MEM = i_dm_req & ~o_dm_valid;

endmodule

`default_nettype wire
